// File: rtl/pass_sched.sv
// Iteration/pass scheduler: sequences forward-0, forward-1 and backward phases per iteration.
// Optional per-phase watchdog is enabled with the PASS_SCHED_WDOG_EN macro.
module pass_sched (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic [3:0] iter_cnt_i,
   input  logic       f0_done_i,
   input  logic       f1_done_i,
   input  logic       b_done_i,
   output logic       f0_pass_o,
   output logic       f1_pass_o,
   output logic       b_pass_o,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic [3:0] iter_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_F0   = 3'd1,
      S_F1   = 3'd2,
      S_BWD  = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   state_t     r_state;
   logic [3:0] r_iter;
   logic [3:0] r_cnt;
   logic       w_start_ok;
   logic       w_wdog_expire;

   assign w_start_ok = start_i && (iter_cnt_i != 4'd0);

`ifdef PASS_SCHED_WDOG_EN
   logic [7:0] r_wdog;
   logic       w_in_phase;
   logic       w_phase_done;

   assign w_in_phase   = (r_state == S_F0) || (r_state == S_F1) || (r_state == S_BWD);
   assign w_phase_done = ((r_state == S_F0)  && f0_done_i) ||
                         ((r_state == S_F1)  && f1_done_i) ||
                         ((r_state == S_BWD) && b_done_i);
   // The enabled cycle that would take the count to 255 is the last chance for a done strobe.
   assign w_wdog_expire = w_in_phase && (r_wdog == 8'd254);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wdog <= 8'd0;
      end else if (en_i) begin
         if (!abort_i && w_in_phase && !w_phase_done && !w_wdog_expire)
            r_wdog <= r_wdog + 8'd1;
         else
            r_wdog <= 8'd0;
      end
   end
`else
   assign w_wdog_expire = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_iter  <= 4'd0;
         r_cnt   <= 4'd0;
      end else if (en_i) begin
         if (abort_i) begin
            r_state <= S_IDLE;
            r_iter  <= 4'd0;
         end else begin
            case (r_state)
               S_IDLE, S_ERR: begin
                  if (w_start_ok) begin
                     r_state <= S_F0;
                     r_cnt   <= iter_cnt_i;
                     r_iter  <= 4'd0;
                  end
               end
               S_F0: begin
                  if (f0_done_i)          r_state <= S_F1;
                  else if (w_wdog_expire) r_state <= S_ERR;
               end
               S_F1: begin
                  if (f1_done_i)          r_state <= S_BWD;
                  else if (w_wdog_expire) r_state <= S_ERR;
               end
               S_BWD: begin
                  if (b_done_i) begin
                     if (r_iter == r_cnt - 4'd1) begin
                        r_state <= S_DONE;
                     end else begin
                        r_iter  <= r_iter + 4'd1;
                        r_state <= S_F0;
                     end
                  end else if (w_wdog_expire) begin
                     r_state <= S_ERR;
                  end
               end
               S_DONE:  r_state <= S_IDLE;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Moore decode: every output is a function of registered state only.
   assign f0_pass_o = (r_state == S_F0);
   assign f1_pass_o = (r_state == S_F1);
   assign b_pass_o  = (r_state == S_BWD);
   assign busy_o    = f0_pass_o || f1_pass_o || b_pass_o;
   assign done_o    = (r_state == S_DONE);
   assign iter_o    = r_iter;
`ifdef PASS_SCHED_WDOG_EN
   assign err_o     = (r_state == S_ERR);
`else
   assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pass_sched.sv
// Directed bench for pass_sched: run sequencing, abort priority, strobe filtering,
// enable freeze, async reset and (with PASS_SCHED_WDOG_EN) the watchdog path.
module tb_pass_sched;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       en_i;
   logic       start_i;
   logic       abort_i;
   logic [3:0] iter_cnt_i;
   logic       f0_done_i;
   logic       f1_done_i;
   logic       b_done_i;
   logic       f0_pass_o;
   logic       f1_pass_o;
   logic       b_pass_o;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic [3:0] iter_o;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [2:0] P0 = 3'b000;
   localparam logic [2:0] PF0 = 3'b100;
   localparam logic [2:0] PF1 = 3'b010;
   localparam logic [2:0] PB = 3'b001;

   pass_sched dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (en_i),
      .start_i    (start_i),
      .abort_i    (abort_i),
      .iter_cnt_i (iter_cnt_i),
      .f0_done_i  (f0_done_i),
      .f1_done_i  (f1_done_i),
      .b_done_i   (b_done_i),
      .f0_pass_o  (f0_pass_o),
      .f1_pass_o  (f1_pass_o),
      .b_pass_o   (b_pass_o),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .iter_o     (iter_o)
   );

   always #5 clk_i = ~clk_i;

   logic [9:0] w_obs;
   assign w_obs = {f0_pass_o, f1_pass_o, b_pass_o, busy_o, done_o, err_o, iter_o};

   // Expected output vector: pass triple {f0,f1,b}, busy, done, err, iter.
   function automatic logic [9:0] ev(input logic [2:0] p, input logic d, input logic e,
                                     input logic [3:0] it);
      return {p, (p != 3'b000), d, e, it};
   endfunction

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Hold a phase three cycles past entry, then strobe its done for one cycle.
   task automatic run_phase(input int which, input logic [9:0] e_in, input string tag);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk(tag, w_obs, e_in);
      end
      case (which)
         0: f0_done_i = 1'b1;
         1: f1_done_i = 1'b1;
         default: b_done_i = 1'b1;
      endcase
      tick();
      f0_done_i = 1'b0;
      f1_done_i = 1'b0;
      b_done_i  = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; en_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; iter_cnt_i = 4'd0;
      f0_done_i = 1'b0; f1_done_i = 1'b0; b_done_i = 1'b0;
      #2 rst_i = 1'b0;
      #1 chk("reset_outputs", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
      tick();
      chk("reset_held", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
      @(negedge clk_i) rst_i = 1'b1;
      tick();
      chk("idle_after_release", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));

      // Zero-iteration start is ignored
      start_i = 1'b1; iter_cnt_i = 4'd0;
      tick();
      chk("start_zero_ignored", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));

      // Two-iteration run, each done three cycles after phase entry
      iter_cnt_i = 4'd2;
      tick();
      start_i = 1'b0; iter_cnt_i = 4'd0;
      chk("run_f0_it0_entry", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      run_phase(0, ev(PF0, 1'b0, 1'b0, 4'd0), "run_f0_it0");
      chk("run_f1_it0_entry", w_obs, ev(PF1, 1'b0, 1'b0, 4'd0));
      run_phase(1, ev(PF1, 1'b0, 1'b0, 4'd0), "run_f1_it0");
      chk("run_b_it0_entry", w_obs, ev(PB, 1'b0, 1'b0, 4'd0));
      run_phase(2, ev(PB, 1'b0, 1'b0, 4'd0), "run_b_it0");
      chk("run_f0_it1_entry", w_obs, ev(PF0, 1'b0, 1'b0, 4'd1));
      run_phase(0, ev(PF0, 1'b0, 1'b0, 4'd1), "run_f0_it1");
      chk("run_f1_it1_entry", w_obs, ev(PF1, 1'b0, 1'b0, 4'd1));
      run_phase(1, ev(PF1, 1'b0, 1'b0, 4'd1), "run_f1_it1");
      chk("run_b_it1_entry", w_obs, ev(PB, 1'b0, 1'b0, 4'd1));
      run_phase(2, ev(PB, 1'b0, 1'b0, 4'd1), "run_b_it1");
      chk("run_done_pulse", w_obs, ev(P0, 1'b1, 1'b0, 4'd1));
      tick();
      chk("run_idle_busy", {9'd0, busy_o}, 10'd0);
      chk("run_idle_done", {9'd0, done_o}, 10'd0);
      tick();
      chk("run_no_second_done", {8'd0, busy_o, done_o}, 10'd0);

      // Abort and last b_done in the same cycle: abort wins
      start_i = 1'b1; iter_cnt_i = 4'd1;
      tick();
      start_i = 1'b0;
      chk("abort_f0", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      f0_done_i = 1'b1; tick(); f0_done_i = 1'b0;
      f1_done_i = 1'b1; tick(); f1_done_i = 1'b0;
      chk("abort_bwd", w_obs, ev(PB, 1'b0, 1'b0, 4'd0));
      b_done_i = 1'b1; abort_i = 1'b1;
      tick();
      b_done_i = 1'b0; abort_i = 1'b0;
      chk("abort_idle", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
      tick();
      chk("abort_no_done", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));

      // Foreign strobes and start ignored in F0
      start_i = 1'b1; iter_cnt_i = 4'd1;
      tick();
      iter_cnt_i = 4'd5;
      f1_done_i = 1'b1;
      tick();
      f1_done_i = 1'b0;
      chk("f0_ignores_f1_done", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      b_done_i = 1'b1;
      tick();
      b_done_i = 1'b0; start_i = 1'b0; iter_cnt_i = 4'd0;
      chk("f0_ignores_b_done", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      f0_done_i = 1'b1; tick(); f0_done_i = 1'b0;
      chk("f0_to_f1", w_obs, ev(PF1, 1'b0, 1'b0, 4'd0));

      // Enable low for 10 cycles in F1 with strobe and abort pulsed
      en_i = 1'b0; f1_done_i = 1'b1; abort_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("freeze_f1", w_obs, ev(PF1, 1'b0, 1'b0, 4'd0));
      end
      en_i = 1'b1; f1_done_i = 1'b0; abort_i = 1'b0;
      tick();
      chk("resume_f1", w_obs, ev(PF1, 1'b0, 1'b0, 4'd0));
      f1_done_i = 1'b1; tick(); f1_done_i = 1'b0;
      b_done_i = 1'b1; tick(); b_done_i = 1'b0;
      chk("single_iter_done", w_obs, ev(P0, 1'b1, 1'b0, 4'd0));
      en_i = 1'b0;
      tick();
      chk("done_held_en_low", w_obs, ev(P0, 1'b1, 1'b0, 4'd0));
      en_i = 1'b1;
      tick();
      chk("done_then_idle", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));

      // Asynchronous reset in BWD
      start_i = 1'b1; iter_cnt_i = 4'd3;
      tick();
      start_i = 1'b0;
      f0_done_i = 1'b1; tick(); f0_done_i = 1'b0;
      f1_done_i = 1'b1; tick(); f1_done_i = 1'b0;
      b_done_i = 1'b1; tick(); b_done_i = 1'b0;
      f0_done_i = 1'b1; tick(); f0_done_i = 1'b0;
      f1_done_i = 1'b1; tick(); f1_done_i = 1'b0;
      chk("pre_reset_bwd", w_obs, ev(PB, 1'b0, 1'b0, 4'd1));
      #1 rst_i = 1'b0;
      #1 chk("async_reset_bwd", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
      @(negedge clk_i) rst_i = 1'b1;
      tick();
      chk("post_reset_idle", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));

`ifdef PASS_SCHED_WDOG_EN
      // Watchdog expiry in F0, then restart from ERR
      start_i = 1'b1; iter_cnt_i = 4'd1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 254; i++) tick();
      chk("wdog_last_f0", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      tick();
      chk("wdog_err", w_obs, ev(P0, 1'b0, 1'b1, 4'd0));
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      chk("wdog_restart", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      for (int i = 0; i < 254; i++) tick();
      f0_done_i = 1'b1; tick(); f0_done_i = 1'b0;
      chk("wdog_done_wins", w_obs, ev(PF1, 1'b0, 1'b0, 4'd0));
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      chk("wdog_abort_idle", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
`else
      // Without the watchdog a phase waits indefinitely
      start_i = 1'b1; iter_cnt_i = 4'd1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 300; i++) tick();
      chk("no_wdog_still_f0", w_obs, ev(PF0, 1'b0, 1'b0, 4'd0));
      abort_i = 1'b1; tick(); abort_i = 1'b0;
      chk("no_wdog_abort_idle", w_obs, ev(P0, 1'b0, 1'b0, 4'd0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
